debounce_bank: RTL and testbench
================================

# debounce_bank

Parametrised multi-channel pushbutton conditioner, the successor to the single-bit `debounce`. It synchronises `CHANNELS` raw button/switch inputs and debounces each independently. Each channel produces a level output, a one-cycle press pulse, a one-cycle release pulse, and optional auto-repeat press pulses while held. It sits between the board buttons and game logic / control, which consume pulses instead of edge-detecting levels themselves.

## Interface
- `CHANNELS`, default 5: number of independent inputs (≥1).
- `STABLE_COUNT`, default 1000000: consecutive stable cycles required before `clean_out` changes (≥1).
- `REPEAT_DELAY`, default 12500000: cycles from initial press pulse to first repeat pulse (≥1).
- `REPEAT_PERIOD`, default 3125000: cycles between subsequent repeat pulses (≥1).
- `REPEAT_MASK`, default all zeros: bit i = 1 enables auto-repeat on channel i.

- `clock_in`, input, 1: sole clock; all state is updated on its rising edge.
- `reset_in`, input, 1: synchronous, active-high reset.
- `noisy_in`, input, `CHANNELS`: raw asynchronous inputs.
- `clean_out`, output, `CHANNELS`: debounced levels.
- `press_out`, output, `CHANNELS`: one-cycle pulse on debounced rise and on each auto-repeat.
- `release_out`, output, `CHANNELS`: one-cycle pulse on debounced fall.

## Operation
- **Per-channel pipeline:** 2-flop synchronizer `s1 -> s2`, then candidate `cand`, stability counter `cnt`, `clean`, and repeat counter `rcnt`.
- **Reset** (`reset_in` high at an edge):
  - `s1`, `s2`, `cand`, `clean_out`, `press_out`, `release_out`, `cnt`, and `rcnt` all go to 0.
  - An input held through reset is reported as a fresh press after settling.
- **Debounce:**
  - If `s2 != cand`: `cand <= s2`, `cnt <= 0`.
  - Else if `cnt == STABLE_COUNT-1`: `clean <= cand`, `cnt` holds at `STABLE_COUNT`. The counter saturates and does not wrap.
  - Else if `cnt < STABLE_COUNT-1`: `cnt <= cnt+1`.
  - A glitch shorter than `STABLE_COUNT` cycles at `s2` never changes `clean_out`.
- **Edges:**
  - `press_out[i]` is high for exactly the cycle in which `clean_out[i]` first reads 1.
  - `release_out[i]` is high for exactly the cycle in which `clean_out[i]` first reads 0.
  - Both are registered in the same edge that updates `clean_out`.
- **Auto-repeat** (only if `REPEAT_MASK[i]`):
  - `rcnt` clears on the initial press edge and increments every cycle `clean_out[i]` stays 1.
  - When `rcnt` reaches `REPEAT_DELAY` (first repeat) or `REPEAT_PERIOD` (later repeats), `press_out[i]` pulses and `rcnt` reloads to 0.
  - A first/subsequent flag selects the threshold.
  - On release, `rcnt` and the flag clear. No repeat pulse is emitted in or after the release cycle.
  - Channels with the mask bit clear produce exactly one press pulse per debounced rise.
- **Counter widths:**
  - `cnt` is `$clog2(STABLE_COUNT+1)` bits.
  - `rcnt` is `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)` bits.
  - No overflow is possible.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- `press_out[i]` and `release_out[i]` are never high in the same cycle.

## Timing
- `noisy_in[i]` changes and then holds from just before edge e:
  - `s2` updates at e+1.
  - `cand` updates at e+2.
  - `clean_out` and the press/release pulse appear after edge e+2+`STABLE_COUNT`.
- Initial press pulse after edge P: repeat pulses after edges P+`REPEAT_DELAY` and P+`REPEAT_DELAY`+k·`REPEAT_PERIOD` (k≥1), each exactly one cycle wide.
- All outputs are registered. There is no combinational path from `noisy_in` to any output.
- Reset asserted mid-count or mid-hold takes effect at that edge, and all outputs read 0 the following cycle. Normal timing restarts from the first edge with `reset_in` low.

## Test plan
Bench parameters for all scenarios: `CHANNELS`=2, `STABLE_COUNT`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `REPEAT_MASK`=2'b10.

1. **Reset values:** assert reset with `noisy_in`=2'b11 → all outputs 0 while reset is held. After release, `clean_out`=2'b11 and both `press_out` bits pulse once, 6 edges after the first non-reset edge.
2. **Clean press/release on ch0:** raise `noisy_in[0]` before edge e → `clean_out[0]`=1 and `press_out[0]` pulses exactly once, after edge e+6. Hold 40 cycles → no further `press_out[0]` pulses. Lower the input → `release_out[0]` pulses 6 edges later.
3. **Bounce rejection:** toggle `noisy_in[0]` every 2 cycles for 12 cycles, then hold 1; separately apply a 3-cycle high glitch → no `clean_out` change during the bounce or glitch. Exactly one `press_out[0]` pulse, 6 edges after the final transition.
4. **Auto-repeat on ch1:** hold `noisy_in[1]`, initial press at P → `press_out[1]` pulses at P, P+10, P+13, P+16, … Release → `release_out[1]` pulses and no further `press_out[1]`. Re-press → delay restarts at 10.
5. **Simultaneous channels:** raise both bits in the same cycle → `press_out`=2'b11 in one cycle. Lower ch0 as ch1 repeats → ch0 release and ch1 repeat pulses are independent and correctly timed.
6. **Reset mid-hold:** pulse reset for 1 cycle during a ch1 hold, after 2 repeats → outputs 0 next cycle. With the input still held, a fresh press occurs 6 edges later, then the first repeat 10 cycles after that.

Source files
------------

// File: rtl/debounce_bank.sv
// Multi-channel pushbutton conditioner. Each channel synchronises its raw
// input, debounces it, and emits press/release pulses plus optional auto-repeat.
module debounce_bank #(
    parameter int                    CHANNELS      = 5,
    parameter int                    STABLE_COUNT  = 1000000,
    parameter int                    REPEAT_DELAY  = 12500000,
    parameter int                    REPEAT_PERIOD = 3125000,
    parameter logic [CHANNELS-1:0]   REPEAT_MASK   = '0
) (
    input  logic                clock_in,
    input  logic                reset_in,
    input  logic [CHANNELS-1:0] noisy_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] press_out,
    output logic [CHANNELS-1:0] release_out
);

    localparam int CNT_W   = $clog2(STABLE_COUNT + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(STABLE_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);
    localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic             s1_reg;
            logic             s2_reg;
            logic             cand_reg;
            logic             clean_reg;
            logic             press_reg;
            logic             release_reg;
            logic             rep_flag_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic [RPT_W-1:0] rcnt_reg;

            logic             clean_next;
            logic             held_next;
            logic             rpt_hit;
            logic [RPT_W-1:0] rcnt_inc;
            logic [RPT_W-1:0] rpt_thresh;

            always_comb begin
                clean_next = clean_reg;
                if ((s2_reg == cand_reg) && (cnt_reg == CNT_LAST)) begin
                    clean_next = cand_reg;
                end
                // Only a channel that was already pressed and stays pressed may repeat,
                // which keeps repeats out of both the initial-press and release cycles.
                held_next  = REPEAT_MASK[gi] && clean_reg && clean_next;
                rcnt_inc   = rcnt_reg + RPT_ONE;
                rpt_thresh = rep_flag_reg ? RPT_NEXT : RPT_FIRST;
                rpt_hit    = held_next && (rcnt_inc == rpt_thresh);
            end

            always_ff @(posedge clock_in) begin
                if (reset_in) begin
                    s1_reg       <= 1'b0;
                    s2_reg       <= 1'b0;
                    cand_reg     <= 1'b0;
                    clean_reg    <= 1'b0;
                    press_reg    <= 1'b0;
                    release_reg  <= 1'b0;
                    rep_flag_reg <= 1'b0;
                    cnt_reg      <= '0;
                    rcnt_reg     <= '0;
                end else begin
                    s1_reg <= noisy_in[gi];
                    s2_reg <= s1_reg;

                    if (s2_reg != cand_reg) begin
                        cand_reg <= s2_reg;
                        cnt_reg  <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= CNT_SAT;
                    end else if (cnt_reg < CNT_LAST) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end

                    clean_reg   <= clean_next;
                    press_reg   <= (clean_next & ~clean_reg) | rpt_hit;
                    release_reg <= clean_reg & ~clean_next;

                    if (held_next) begin
                        if (rpt_hit) begin
                            rcnt_reg     <= '0;
                            rep_flag_reg <= 1'b1;
                        end else begin
                            rcnt_reg <= rcnt_inc;
                        end
                    end else begin
                        rcnt_reg     <= '0;
                        rep_flag_reg <= 1'b0;
                    end
                end
            end

            assign clean_out[gi]   = clean_reg;
            assign press_out[gi]   = press_reg;
            assign release_out[gi] = release_reg;
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: stimulus schedules expected pulse events
// into a scoreboard queue that is drained and compared every cycle.
module tb_debounce_bank;

    localparam int         CH    = 2;
    localparam int         SC    = 4;
    localparam int         RD    = 10;
    localparam int         RP    = 3;
    localparam logic [1:0] MASK  = 2'b10;
    localparam int         LAT   = SC + 3;

    typedef struct {
        int cyc;
        int ch;
        int kind;   // 0 initial press, 1 repeat press, 2 release
    } ev_t;

    logic          clock_in = 1'b0;
    logic          reset_in;
    logic [CH-1:0] noisy_in;
    logic [CH-1:0] clean_out;
    logic [CH-1:0] press_out;
    logic [CH-1:0] release_out;

    ev_t           sb[$];
    logic [CH-1:0] exp_clean;
    logic [CH-1:0] exp_p;
    logic [CH-1:0] exp_r;
    int            cyc      = 0;
    int            n_assert = 0;
    int            n_fail   = 0;

    debounce_bank #(
        .CHANNELS      (CH),
        .STABLE_COUNT  (SC),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .REPEAT_MASK   (MASK)
    ) dut (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .noisy_in    (noisy_in),
        .clean_out   (clean_out),
        .press_out   (press_out),
        .release_out (release_out)
    );

    always #5 clock_in = ~clock_in;

    function automatic void push(int c, int ch, int kind);
        ev_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = kind;
        sb.push_back(e);
    endfunction

    // Input on ch raised after edge c and lowered after edge c+len.
    function automatic void sched(int ch, int c, int len);
        int p;
        int r;
        p = c + LAT;
        r = c + len + LAT;
        push(p, ch, 0);
        if (MASK[ch]) begin
            for (int t = p + RD; t < r; t += RP) push(t, ch, 1);
        end
        push(r, ch, 2);
    endfunction

    task automatic step();
        logic rst_seen;
        rst_seen = reset_in;
        @(posedge clock_in);
        #1;
        cyc++;
        if (rst_seen) begin
            sb.delete();
            exp_clean = '0;
        end
        exp_p = '0;
        exp_r = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    0: begin exp_p[sb[i].ch] = 1'b1; exp_clean[sb[i].ch] = 1'b1; end
                    1: exp_p[sb[i].ch] = 1'b1;
                    default: begin exp_r[sb[i].ch] = 1'b1; exp_clean[sb[i].ch] = 1'b0; end
                endcase
                sb.delete(i);
            end
        end
        $display("cyc=%0d rst=%b noisy=%b clean=%b press=%b release=%b",
                 cyc, rst_seen, noisy_in, clean_out, press_out, release_out);
        n_assert++;
        assert (press_out === exp_p) else begin
            n_fail++;
            $error("FAIL press cyc=%0d observed=%b expected=%b", cyc, press_out, exp_p);
        end
        n_assert++;
        assert (release_out === exp_r) else begin
            n_fail++;
            $error("FAIL release cyc=%0d observed=%b expected=%b", cyc, release_out, exp_r);
        end
        n_assert++;
        assert (clean_out === exp_clean) else begin
            n_fail++;
            $error("FAIL clean cyc=%0d observed=%b expected=%b", cyc, clean_out, exp_clean);
        end
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    int c0;

    initial begin
        exp_clean = '0;
        reset_in  = 1'b1;
        noisy_in  = 2'b11;

        // Reset with both inputs held, then fresh presses after release
        run(3);
        reset_in = 1'b0;
        sched(0, cyc, 20);
        sched(1, cyc, 20);
        run(20);
        noisy_in = 2'b00;
        run(10);

        // Clean press, long hold without repeat, release on ch0
        noisy_in[0] = 1'b1;
        sched(0, cyc, 46);
        run(46);
        noisy_in[0] = 1'b0;
        run(10);

        // Bounce then settle high, and a short glitch
        for (int k = 0; k < 6; k++) begin
            noisy_in[0] = ~noisy_in[0];
            run(2);
        end
        noisy_in[0] = 1'b1;
        sched(0, cyc, 15);
        run(15);
        noisy_in[0] = 1'b0;
        run(10);
        noisy_in[0] = 1'b1;
        run(3);
        noisy_in[0] = 1'b0;
        run(10);

        // Auto-repeat on ch1, release, then re-press restarts the delay
        noisy_in[1] = 1'b1;
        sched(1, cyc, 30);
        run(30);
        noisy_in[1] = 1'b0;
        run(10);
        noisy_in[1] = 1'b1;
        sched(1, cyc, 22);
        run(22);
        noisy_in[1] = 1'b0;
        run(10);

        // Simultaneous press; ch0 release lands on ch1's first repeat
        noisy_in = 2'b11;
        sched(0, cyc, 10);
        sched(1, cyc, 25);
        run(10);
        noisy_in[0] = 1'b0;
        run(15);
        noisy_in[1] = 1'b0;
        run(10);

        // One-cycle reset during a ch1 hold after two repeats
        noisy_in[1] = 1'b1;
        c0 = cyc;
        push(c0 + LAT, 1, 0);
        push(c0 + LAT + RD, 1, 1);
        push(c0 + LAT + RD + RP, 1, 1);
        run(LAT + RD + RP);
        reset_in = 1'b1;
        run(1);
        reset_in = 1'b0;
        sched(1, cyc, 20);
        run(20);
        noisy_in[1] = 1'b0;
        run(10);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL leftover_events observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
